// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: carries {inst, addr, fault} from fetch to decode with
// valid/ready handshaking, an optional 2-entry skid buffer and flush.
module if_id_pipe #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter logic [ILEN-1:0] NOP_INST   = 32'h00000013,
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h00000000,
  parameter int unsigned     SKID       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            fault_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [ILEN-1:0]   main_inst_q, main_inst_d;
  logic [XLEN-1:0]   main_addr_q, main_addr_d;
  logic              main_fault_q, main_fault_d;
  logic [ILEN-1:0]   skid_inst_q, skid_inst_d;
  logic [XLEN-1:0]   skid_addr_q, skid_addr_d;
  logic              skid_fault_q, skid_fault_d;

  logic in_fire, out_fire;

  // Handshake decode; with the skid buffer in_ready depends on state only.
  always_comb begin
    out_valid = (state_q != StEmpty);
    if (SKID != 0) begin
      in_ready = (state_q != StFull);
    end else begin
      in_ready = !out_valid || out_ready;
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // Output mux: NOP and no fault whenever nothing valid is held.
  always_comb begin
    inst_o      = out_valid ? main_inst_q : NOP_INST;
    inst_addr_o = main_addr_q;
    fault_o     = out_valid && main_fault_q;
  end

  // Next-state and storage update; flush overrides every other transition.
  always_comb begin
    state_d      = state_q;
    main_inst_d  = main_inst_q;
    main_addr_d  = main_addr_q;
    main_fault_d = main_fault_q;
    skid_inst_d  = skid_inst_q;
    skid_addr_d  = skid_addr_q;
    skid_fault_d = skid_fault_q;
    if (flush_i) begin
      // Main keeps its contents so inst_addr_o holds; the skid entry is dropped.
      state_d      = StEmpty;
      skid_inst_d  = '0;
      skid_addr_d  = '0;
      skid_fault_d = 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d      = StOne;
            main_inst_d  = inst_i;
            main_addr_d  = inst_addr_i;
            main_fault_d = fault_i;
          end
        end
        StOne: begin
          if (in_fire && (out_fire || SKID == 0)) begin
            main_inst_d  = inst_i;
            main_addr_d  = inst_addr_i;
            main_fault_d = fault_i;
          end else if (in_fire) begin
            state_d      = StFull;
            skid_inst_d  = inst_i;
            skid_addr_d  = inst_addr_i;
            skid_fault_d = fault_i;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d      = StOne;
            main_inst_d  = skid_inst_q;
            main_addr_d  = skid_addr_q;
            main_fault_d = skid_fault_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and entry registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StEmpty;
      main_inst_q  <= NOP_INST;
      main_addr_q  <= RESET_ADDR;
      main_fault_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_addr_q  <= '0;
      skid_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_inst_q  <= main_inst_d;
      main_addr_q  <= main_addr_d;
      main_fault_q <= main_fault_d;
      skid_inst_q  <= skid_inst_d;
      skid_addr_q  <= skid_addr_d;
      skid_fault_q <= skid_fault_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: one SKID=1 instance and one SKID=0 instance.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;

  // SKID=1 instance signals
  logic        a_in_valid, a_in_ready, a_fault_i, a_flush, a_out_valid, a_out_ready, a_fault_o;
  logic [31:0] a_inst_i, a_addr_i, a_inst_o, a_addr_o;
  // SKID=0 instance signals
  logic        b_in_valid, b_in_ready, b_fault_i, b_flush, b_out_valid, b_out_ready, b_fault_o;
  logic [31:0] b_inst_i, b_addr_i, b_inst_o, b_addr_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_pipe #(.SKID(1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .inst_i(a_inst_i),
    .inst_addr_i(a_addr_i), .fault_i(a_fault_i), .flush_i(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .inst_o(a_inst_o), .inst_addr_o(a_addr_o), .fault_o(a_fault_o)
  );

  if_id_pipe #(.SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .inst_i(b_inst_i),
    .inst_addr_i(b_addr_i), .fault_i(b_fault_i), .flush_i(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .inst_o(b_inst_o), .inst_addr_o(b_addr_o), .fault_o(b_fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive an instruction on the SKID=1 side; inst encodes the address.
  task automatic drive_a(input logic v, input logic [31:0] addr, input logic f);
    a_in_valid = v;
    a_addr_i   = addr;
    a_inst_i   = 32'hA000_0000 | addr;
    a_fault_i  = f;
  endtask

  initial begin
    rst = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0);
    a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_inst_i = '0; b_addr_i = '0; b_fault_i = 1'b0;
    b_flush = 1'b0; b_out_ready = 1'b0;

    // Reset values
    #3;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_inst", a_inst_o, NOP);
    chk("rst_a_addr", a_addr_o, 32'h0);
    chk("rst_a_fault", a_fault_o, 0);
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_ready", b_in_ready, 1);
    #4 rst = 1'b1;
    cyc();

    // First instruction: 1-cycle latency
    a_in_valid = 1'b1; a_inst_i = 32'h00500093; a_addr_i = 32'h100; a_out_ready = 1'b1;
    #1;
    chk("t1_pre_valid", a_out_valid, 0);
    chk("t1_pre_inst", a_inst_o, NOP);
    chk("t1_pre_addr", a_addr_o, 32'h0);
    cyc();
    a_in_valid = 1'b0;
    #1;
    chk("t1_valid", a_out_valid, 1);
    chk("t1_inst", a_inst_o, 32'h00500093);
    chk("t1_addr", a_addr_o, 32'h100);
    cyc();
    chk("t1_drain_valid", a_out_valid, 0);
    chk("t1_drain_inst", a_inst_o, NOP);
    chk("t1_hold_addr", a_addr_o, 32'h100);

    // Skid stream 0x0,0x4,0x8,0xC with backpressure
    drive_a(1'b1, 32'h0, 1'b0); a_out_ready = 1'b1;
    cyc();
    drive_a(1'b1, 32'h4, 1'b0); a_out_ready = 1'b0;
    #1;
    chk("s_c1_ready", a_in_ready, 1);
    chk("s_c1_addr", a_addr_o, 32'h0);
    cyc();
    drive_a(1'b1, 32'h8, 1'b0);
    #1;
    chk("s_full_ready", a_in_ready, 0);
    chk("s_full_addr", a_addr_o, 32'h0);
    chk("s_full_inst", a_inst_o, 32'hA000_0000);
    cyc();
    a_out_ready = 1'b1;
    #1;
    chk("s_c3_ready", a_in_ready, 0);
    chk("s_out0", a_addr_o, 32'h0);
    cyc();
    chk("s_out4", a_addr_o, 32'h4);
    chk("s_c4_ready", a_in_ready, 1);
    cyc();
    drive_a(1'b1, 32'hC, 1'b0);
    #1;
    chk("s_out8", a_addr_o, 32'h8);
    cyc();
    drive_a(1'b0, 32'h0, 1'b0);
    #1;
    chk("s_outC", a_addr_o, 32'hC);
    chk("s_outC_inst", a_inst_o, 32'hA000_000C);
    chk("s_outC_valid", a_out_valid, 1);
    cyc();
    chk("s_empty", a_out_valid, 0);

    // Flush while FULL drops both held entries and the incoming one
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h20, 1'b0);
    cyc();
    drive_a(1'b1, 32'h24, 1'b0);
    cyc();
    drive_a(1'b1, 32'h28, 1'b0); a_flush = 1'b1;
    #1;
    chk("f_ready_in_flush", a_in_ready, 0);
    chk("f_pre_addr", a_addr_o, 32'h20);
    cyc();
    a_flush = 1'b0; drive_a(1'b0, 32'h0, 1'b0); a_out_ready = 1'b1;
    #1;
    chk("f_valid", a_out_valid, 0);
    chk("f_inst", a_inst_o, NOP);
    chk("f_ready", a_in_ready, 1);
    cyc();
    chk("f_no28_valid", a_out_valid, 0);

    // Fault sideband
    drive_a(1'b1, 32'h40, 1'b1);
    #1;
    chk("fl_pre", a_fault_o, 0);
    cyc();
    drive_a(1'b1, 32'h44, 1'b0);
    #1;
    chk("fl_40", a_fault_o, 1);
    chk("fl_40_addr", a_addr_o, 32'h40);
    cyc();
    drive_a(1'b0, 32'h0, 1'b0);
    #1;
    chk("fl_44", a_fault_o, 0);
    chk("fl_44_addr", a_addr_o, 32'h44);
    cyc();
    chk("fl_empty", a_fault_o, 0);

    // SKID=0: streaming, in_ready follows out_ready combinationally
    b_out_ready = 1'b1; b_in_valid = 1'b1;
    b_addr_i = 32'h200; b_inst_i = 32'hB000_0200;
    cyc();
    for (int i = 1; i < 8; i++) begin
      b_addr_i = 32'h200 + 32'(i * 4);
      b_inst_i = 32'hB000_0000 | b_addr_i;
      #1;
      chk("b_valid", b_out_valid, 1);
      chk("b_addr", b_addr_o, 32'h200 + 32'((i - 1) * 4));
      chk("b_ready_hi", b_in_ready, 1);
      b_out_ready = 1'b0;
      #1;
      chk("b_ready_lo", b_in_ready, 0);
      b_out_ready = 1'b1;
      cyc();
    end
    b_in_valid = 1'b0;
    #1;
    chk("b_last_addr", b_addr_o, 32'h21C);
    chk("b_last_inst", b_inst_o, 32'hB000_021C);
    cyc();
    chk("b_empty", b_out_valid, 0);

    // Asynchronous reset while FULL
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h60, 1'b1);
    cyc();
    drive_a(1'b1, 32'h64, 1'b0);
    cyc();
    drive_a(1'b0, 32'h0, 1'b0);
    #1;
    chk("ar_full_ready", a_in_ready, 0);
    chk("ar_full_fault", a_fault_o, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_valid", a_out_valid, 0);
    chk("ar_inst", a_inst_o, NOP);
    chk("ar_addr", a_addr_o, 32'h0);
    chk("ar_fault", a_fault_o, 0);
    chk("ar_ready", a_in_ready, 1);
    #1 rst = 1'b1;
    cyc();
    drive_a(1'b1, 32'h70, 1'b0); a_out_ready = 1'b1;
    #1;
    chk("ar_post_pre", a_out_valid, 0);
    cyc();
    drive_a(1'b0, 32'h0, 1'b0);
    #1;
    chk("ar_post_valid", a_out_valid, 1);
    chk("ar_post_addr", a_addr_o, 32'h70);
    cyc();
    chk("ar_post_empty", a_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- Parametrised IF/ID pipeline stage for the RISC-V core; the next generation of the plain IF/ID register.
- Carries instruction and instruction address from fetch to decode.
- Adds valid/ready handshaking, an optional 2-entry skid buffer (registered ready), flush with NOP insertion, and a fetch-fault sideband bit.
- Sits between the instruction-fetch unit and the decoder.

Parameters:
- XLEN, 32, width of instruction address.
- ILEN, 32, width of instruction word.
- NOP_INST, 32'h00000013, instruction (addi x0,x0,0) driven on inst_o when the stage holds nothing valid.
- RESET_ADDR, 32'h00000000, inst_addr_o value after reset.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, in_ready = !out_valid | out_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- inst_i  in  ILEN  fetched instruction.
- inst_addr_i  in  XLEN  address of inst_i.
- fault_i  in  1  fetch fault flag for inst_i.
- flush_i  in  1  discard all held and incoming entries (branch/jump/trap).
- out_valid  out  1  decode-side valid.
- out_ready  in  1  decode accepts.
- inst_o  out  ILEN  instruction to decode.
- inst_addr_o  out  XLEN  address to decode.
- fault_o  out  1  fault flag to decode.

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry {inst, addr, fault}; with SKID=1, an extra skid entry of the same fields.
- Reset (rst=0, asynchronous): state EMPTY; main = {NOP_INST, RESET_ADDR, 0}; skid cleared; out_valid=0; inst_o=NOP_INST; inst_addr_o=RESET_ADDR; fault_o=0; in_ready=1.
- State machine, SKID=1, states EMPTY / ONE / FULL:
  - EMPTY: in_fire -> ONE, main <= input.
  - ONE: in_fire & out_fire -> ONE, main <= input. in_fire & !out_fire -> FULL, skid <= input. !in_fire & out_fire -> EMPTY.
  - FULL: out_fire -> ONE, main <= skid. No in_fire is possible in FULL.
- in_ready = (state != FULL). It is decoded from the state register only; there is no combinational path from out_ready.
- SKID=1 latency: 1 cycle from in_fire to out_valid.
- SKID=0: only states EMPTY and ONE exist.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main, state ONE.
  - out_fire without in_fire -> EMPTY.
- Outputs:
  - out_valid = (state != EMPTY).
  - inst_o = out_valid ? main.inst : NOP_INST.
  - inst_addr_o = main.addr (holds last value when empty).
  - fault_o = out_valid & main.fault.
- Held outputs: while out_valid & !out_ready, inst_o, inst_addr_o and fault_o are stable.
- flush_i has highest priority:
  - Next state is EMPTY regardless of in_fire/out_fire in the same cycle.
  - An input accepted in the flush cycle is dropped.
  - Skid entry is discarded.
  - inst_o reads NOP_INST on the next cycle.
  - in_ready still follows its rule during the flush cycle.
- Reset asserted mid-operation: immediate return to reset values; all in-flight entries are lost.
- No data reordering; entries leave in acceptance order.

Test Plan:
- Reset, then in_valid=1, inst_i=32'h00500093, addr=0x100, out_ready=1 -> next cycle out_valid=1, inst_o=32'h00500093, inst_addr_o=0x100; before that, inst_o=NOP_INST and inst_addr_o=0.
- SKID=1: stream addrs 0x0, 0x4, 0x8, 0xC with out_ready=0 from the second cycle -> in_ready drops after 2 accepts. Then out_ready=1 -> outputs 0x0, 0x4, 0x8, 0xC in order, none lost or duplicated.
- State FULL (entries 0x20, 0x24) with flush_i=1 and in_valid=1 for addr 0x28 -> next cycle out_valid=0, inst_o=32'h00000013, in_ready=1; 0x28 is never output.
- SKID=0: out_valid=1, out_ready=1, in_valid=1 every cycle for 8 instructions -> one output per cycle, and in_ready tracks out_ready combinationally in the same cycle.
- fault_i=1 on addr 0x40, then fault_i=0 on addr 0x44 -> fault_o=1 only while 0x40 is presented; fault_o=0 when out_valid=0.
- rst pulled low while FULL, asynchronously between clock edges -> outputs return to reset values immediately, without a clock edge; after release, the first accepted instruction appears with 1-cycle latency.
